// File: rtl/vga_framebuffer.sv
// Dual-port RGB332 cell framebuffer for vga_driver, with a hardware clear engine.
// Optional CPU readback port enabled by defining FB_READBACK_EN.
module vga_framebuffer #(
    parameter int H_CELLS    = 80,
    parameter int V_CELLS    = 60,
    parameter int SCALE_LOG2 = 3,
    parameter int AW         = 13
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [9:0]    ROW,
    input  logic [9:0]    COLUMN,
    output logic [2:0]    RED,
    output logic [2:0]    GREEN,
    output logic [1:0]    BLUE,
    input  logic [AW-1:0] WA,
    input  logic [7:0]    WD,
    input  logic          WE,
    input  logic          CLR,
    input  logic [7:0]    CLR_COLOR,
    output logic          BUSY,
    output logic [7:0]    RD
);

    localparam int            CELLS   = H_CELLS * V_CELLS;
    localparam logic [AW-1:0] LAST    = AW'(CELLS - 1);
    localparam logic [AW-1:0] H_MUL   = AW'(H_CELLS);
    localparam logic [9:0]    ROW_LIM = 10'(V_CELLS << SCALE_LOG2);
    localparam logic [9:0]    COL_LIM = 10'(H_CELLS << SCALE_LOG2);

    typedef enum logic {IDLE, CLEARING} state_t;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_req_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [7:0]    fill;
    logic          busy_q;
    wr_req_t       wr;

    logic [7:0]    mem [0:CELLS-1];

    // Clear engine: one cell per cycle, BUSY registered alongside the state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            fill   <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CLR) begin
                        state  <= CLEARING;
                        fill   <= CLR_COLOR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEARING: begin
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write port arbitration; a reset edge also aborts the in-flight clear write.
    always_comb begin
        wr = '0;
        if (RST_N) begin
            if (state == CLEARING) begin
                wr.en   = 1'b1;
                wr.addr = cnt;
                wr.data = fill;
            end else if (WE && (WA <= LAST)) begin
                wr.en   = 1'b1;
                wr.addr = WA;
                wr.data = WD;
            end
        end
    end

`ifdef FB_READBACK_EN
    logic [7:0] rd_q;

    // Read-first: RD sees the cell value from before any same-edge write.
    always_ff @(posedge CLK) begin
        if (wr.en)
            mem[wr.addr] <= wr.data;
        if (!RST_N)
            rd_q <= '0;
        else if (WA <= LAST)
            rd_q <= mem[WA];
        else
            rd_q <= '0;
    end

    assign RD = rd_q;
`else
    always_ff @(posedge CLK) begin
        if (wr.en)
            mem[wr.addr] <= wr.data;
    end

    assign RD = 8'h00;
`endif

    logic [AW-1:0] cy, cx, vid_addr;
    logic          in_rng;
    logic          vid_vld;
    logic [7:0]    vid_q;

    assign cy       = AW'(ROW >> SCALE_LOG2);
    assign cx       = AW'(COLUMN >> SCALE_LOG2);
    assign vid_addr = cy * H_MUL + cx;
    assign in_rng   = (ROW < ROW_LIM) && (COLUMN < COL_LIM);

    // Out-of-range beam positions skip the read so they cannot alias onto a real cell.
    always_ff @(posedge CLK) begin
        if (in_rng)
            vid_q <= mem[vid_addr];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N)
            vid_vld <= 1'b0;
        else
            vid_vld <= in_rng;
    end

    assign {RED, GREEN, BLUE} = vid_vld ? vid_q : 8'h00;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Scoreboard bench for vga_framebuffer: video reads, CPU writes, clear engine, reset abort.
module tb_vga_framebuffer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [9:0]  ROW, COLUMN;
    logic [2:0]  RED, GREEN;
    logic [1:0]  BLUE;
    logic [12:0] WA;
    logic [7:0]  WD;
    logic        WE, CLR;
    logic [7:0]  CLR_COLOR;
    logic        BUSY;
    logic [7:0]  RD;

    int errors = 0;
    int checks = 0;

    logic [7:0] model [0:4799];
    logic [7:0] exp_q [$];

    vga_framebuffer dut (
        .CLK(CLK), .RST_N(RST_N), .ROW(ROW), .COLUMN(COLUMN),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
        .WA(WA), .WD(WD), .WE(WE), .CLR(CLR), .CLR_COLOR(CLR_COLOR),
        .BUSY(BUSY), .RD(RD)
    );

    always #20 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic vid_probe(input logic [9:0] r, input logic [9:0] c,
                             input logic [7:0] exp, input string nm);
        logic [7:0] e, act;
        ROW = r;
        COLUMN = c;
        exp_q.push_back(exp);
        tick;
        e = exp_q.pop_front();
        act = {RED, GREEN, BLUE};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: rgb=%02h expected %02h", nm, act, e);
        end
    endtask

    task automatic cpu_write(input logic [12:0] a, input logic [7:0] d);
        WA = a;
        WD = d;
        WE = 1'b1;
        tick;
        WE = 1'b0;
        if (a < 13'd4800) model[a] = d;
    endtask

    task automatic start_clear(input logic [7:0] color);
        CLR = 1'b1;
        CLR_COLOR = color;
        tick;
        CLR = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (BUSY === 1'b1 && n < 6000) begin
            tick;
            n++;
        end
    endtask

    task automatic check_busy_len(input int n, input int want, input string nm);
        checks++;
        if (n != want) begin
            errors++;
            $display("FAIL %s: busy cycles=%0d expected %0d", nm, n, want);
        end
    endtask

    // Streams every cell through the video port, one per cycle, pipelined against the 1-cycle latency.
    task automatic scan(input string nm);
        int bad = 0;
        int first = -1;
        logic [7:0] fa = 8'h00, fe = 8'h00;
        logic [7:0] e, act;
        for (int k = 0; k <= 4800; k++) begin
            if (k > 0) begin
                e = exp_q.pop_front();
                act = {RED, GREEN, BLUE};
                if (act !== e) begin
                    bad++;
                    if (first < 0) begin first = k - 1; fa = act; fe = e; end
                end
            end
            if (k < 4800) begin
                ROW    = 10'((k / 80) * 8 + (k % 8));
                COLUMN = 10'((k % 80) * 8 + ((k * 3) % 8));
                exp_q.push_back(model[k]);
                tick;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad cells, first cell %0d rgb=%02h expected %02h", nm, bad, first, fa, fe);
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        ROW = 10'd0; COLUMN = 10'd0;
        WA = 13'd0; WD = 8'h00; WE = 1'b0; CLR = 1'b0; CLR_COLOR = 8'h00;
        tick; tick;
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: BUSY=%b expected 0", BUSY); end
        checks++;
        if ({RED, GREEN, BLUE} !== 8'h00) begin
            errors++; $display("FAIL reset_rgb: rgb=%02h expected 00", {RED, GREEN, BLUE});
        end
        checks++;
        if (RD !== 8'h00) begin errors++; $display("FAIL reset_rd: RD=%02h expected 00", RD); end
        RST_N = 1'b1;
        tick;
    endtask

    task automatic test_init_clear;
        int n;
        start_clear(8'h00);
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL busy_rise: BUSY=%b expected 1", BUSY); end
        wait_busy(n);
        check_busy_len(n, 4800, "init_clear_len");
        for (int i = 0; i < 4800; i++) model[i] = 8'h00;
    endtask

    task automatic test_pixel;
        cpu_write(13'd0, 8'hE0);
        cpu_write(13'd1, 8'h4A);
        for (int c = 0; c < 8; c++)
            vid_probe(10'd0, 10'(c), 8'hE0, "cell0_col");
        vid_probe(10'd0, 10'd8, 8'h4A, "cell1_col8");
        vid_probe(10'd7, 10'd7, 8'hE0, "cell0_corner");
        vid_probe(10'd8, 10'd0, 8'h00, "cell80_row8");
    endtask

    task automatic test_corner;
        cpu_write(13'd4799, 8'h03);
        cpu_write(13'd80, 8'h77);
        vid_probe(10'd479, 10'd639, 8'h03, "last_cell");
        vid_probe(10'd480, 10'd639, 8'h00, "row_480");
        vid_probe(10'd479, 10'd640, 8'h00, "col_640");
        vid_probe(10'd0, 10'd640, 8'h00, "col_alias");
        vid_probe(10'd8, 10'd0, 8'h77, "cell80");
    endtask

    task automatic test_clear;
        int n = 0;
        start_clear(8'h1C);
        while (BUSY === 1'b1 && n < 6000) begin
            WE = (n == 10);
            WA = 13'd5;
            WD = 8'hFF;
            CLR = (n == 20);
            CLR_COLOR = 8'h55;
            tick;
            n++;
        end
        WE = 1'b0;
        CLR = 1'b0;
        check_busy_len(n, 4800, "clear_len");
        for (int i = 0; i < 4800; i++) model[i] = 8'h1C;
        scan("clear_fill");
    endtask

    task automatic test_back_to_back;
        int n;
        WA = 13'd7; WD = 8'hAA; WE = 1'b1;
        CLR = 1'b1; CLR_COLOR = 8'h33;
        tick;
        WE = 1'b0; CLR = 1'b0;
        vid_probe(10'd0, 10'd56, 8'hAA, "we_clr_commit");
        wait_busy(n);
        check_busy_len(n, 4799, "we_clr_len");
        vid_probe(10'd0, 10'd56, 8'h33, "we_clr_overwrite");
        vid_probe(10'd479, 10'd639, 8'h33, "we_clr_last");
        for (int i = 0; i < 4800; i++) model[i] = 8'h33;
    endtask

    task automatic test_reset_mid_clear;
        int n;
        start_clear(8'h00);
        wait_busy(n);
        for (int i = 0; i < 4800; i++) model[i] = 8'h00;
        start_clear(8'hFF);
        for (int i = 0; i < 100; i++) tick;
        RST_N = 1'b0;
        tick;
        RST_N = 1'b1;
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: BUSY=%b expected 0", BUSY); end
        for (int i = 0; i < 100; i++) model[i] = 8'hFF;
        scan("abort_fill");
    endtask

    task automatic test_oob_write;
        cpu_write(13'd4800, 8'hAA);
        vid_probe(10'd0, 10'd0, 8'hFF, "oob_cell0");
        vid_probe(10'd479, 10'd639, 8'h00, "oob_cell4799");
        scan("oob_scan");
    endtask

    task automatic test_readback;
        logic [7:0] want;
        cpu_write(13'd123, 8'h5A);
        WA = 13'd123;
        tick;
`ifdef FB_READBACK_EN
        want = 8'h5A;
`else
        want = 8'h00;
`endif
        checks++;
        if (RD !== want) begin errors++; $display("FAIL rd_cell123: RD=%02h expected %02h", RD, want); end
        WA = 13'd4800;
        tick;
        checks++;
        if (RD !== 8'h00) begin errors++; $display("FAIL rd_oob: RD=%02h expected 00", RD); end
    endtask

    initial begin
        test_reset;
        test_init_clear;
        test_pixel;
        test_corner;
        test_clear;
        test_back_to_back;
        test_reset_mid_clear;
        test_oob_write;
        test_readback;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
